// File: rtl/qdec_cabac_ctu_sched.sv
// CABAC CTU scheduler: walks a picture in raster order, issuing one CTU at a
// time to the CTU decoder, with slice-end, per-CTU watchdog and abort handling.
module qdec_cabac_ctu_sched #(
  parameter int          CTU_DIM_W   = 10,
  parameter int          TIMEOUT_W   = 16,
  parameter int unsigned TIMEOUT_MAX = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cabac_start,
  input  logic [CTU_DIM_W-1:0]   pic_w_ctu,
  input  logic [CTU_DIM_W-1:0]   pic_h_ctu,
  input  logic                   abort,
  output logic                   ctu_start,
  output logic [CTU_DIM_W-1:0]   ctu_x,
  output logic [CTU_DIM_W-1:0]   ctu_y,
  input  logic                   ctu_done,
  input  logic                   end_of_slice,
  output logic [2*CTU_DIM_W-1:0] ctu_count,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   err_timeout,
  output logic                   err_cfg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam logic [CTU_DIM_W-1:0]   DIM_ONE = CTU_DIM_W'(1);
  localparam logic [TIMEOUT_W-1:0]   WD_LAST = TIMEOUT_W'(TIMEOUT_MAX - 1);
  localparam logic [2*CTU_DIM_W-1:0] CNT_MAX = '1;

  logic [2:0]           state;
  logic [CTU_DIM_W-1:0] pic_w_q;
  logic [CTU_DIM_W-1:0] pic_h_q;
  logic [TIMEOUT_W-1:0] watchdog;
  logic                 last_col;
  logic                 last_row;

  // Position tests use the dimensions captured in LOAD, never the live inputs.
  assign last_col = (ctu_x == pic_w_q - DIM_ONE);
  assign last_row = (ctu_y == pic_h_q - DIM_ONE);

  assign ctu_start  = (state == S_ISSUE);
  assign frame_done = (state == S_DONE);
  assign busy       = (state == S_LOAD) || (state == S_ISSUE) || (state == S_WAIT) ||
                      (state == S_NEXT) || (state == S_DONE);

  // NOTE: every register here is state, so all updates are non-blocking and the
  // synchronous reset clears each one explicitly, including the latched dimensions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pic_w_q     <= '0;
      pic_h_q     <= '0;
      ctu_x       <= '0;
      ctu_y       <= '0;
      ctu_count   <= '0;
      watchdog    <= '0;
      err_timeout <= 1'b0;
      err_cfg     <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      // Abort overrides every other transition; sticky flags survive until the next start.
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (cabac_start) begin
            state       <= S_LOAD;
            ctu_count   <= '0;
            err_timeout <= 1'b0;
            err_cfg     <= 1'b0;
          end
        end
        S_LOAD: begin
          pic_w_q <= pic_w_ctu;
          pic_h_q <= pic_h_ctu;
          ctu_x   <= '0;
          ctu_y   <= '0;
          if (pic_w_ctu == '0 || pic_h_ctu == '0) begin
            state   <= S_ERR;
            err_cfg <= 1'b1;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          watchdog <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // A completion in the final watchdog cycle still counts as a completion.
          if (ctu_done) begin
            if (ctu_count != CNT_MAX) ctu_count <= ctu_count + 1'b1;
            if (end_of_slice || (last_col && last_row)) state <= S_DONE;
            else                                        state <= S_NEXT;
          end else if (watchdog == WD_LAST) begin
            state       <= S_ERR;
            err_timeout <= 1'b1;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        S_NEXT: begin
          if (last_col) begin
            ctu_x <= '0;
            ctu_y <= ctu_y + DIM_ONE;
          end else begin
            ctu_x <= ctu_x + DIM_ONE;
          end
          state <= S_ISSUE;
        end
        S_DONE: state <= S_IDLE;
        S_ERR: begin
          if (cabac_start) begin
            state       <= S_LOAD;
            ctu_count   <= '0;
            err_timeout <= 1'b0;
            err_cfg     <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
